// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and HI/LO write-enable codes for the
// multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [1:0] HILO_WE_BOTH = 2'b11;
    localparam logic [1:0] HILO_WE_HI   = 2'b01;
    localparam logic [1:0] HILO_WE_LO   = 2'b00;
    localparam logic [1:0] HILO_WE_NONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        WB   = 2'b11
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_div_radix2.sv
// Unsigned 32-iteration restoring divider.  quotient/remainder/done show the
// result of the step taken in the current cycle, so the caller can register
// the final result on the same edge that retires the last iteration.
module div_radix2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        active;
    logic [4:0]  cnt;
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    logic [31:0] b_reg;
    logic [32:0] r_shift;
    logic [32:0] diff;
    logic        ge;

    // q_reg starts as the dividend and shifts its bits into the remainder
    always_comb begin
        r_shift   = {r_reg, q_reg[31]};
        diff      = r_shift - {1'b0, b_reg};
        ge        = (r_shift >= {1'b0, b_reg});
        quotient  = {q_reg[30:0], ge};
        remainder = ge ? diff[31:0] : r_shift[31:0];
        done      = active && (cnt == 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= 5'd0;
            q_reg  <= 32'd0;
            r_reg  <= 32'd0;
            b_reg  <= 32'd0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= 5'd31;
            q_reg  <= dividend;
            r_reg  <= 32'd0;
            b_reg  <= divisor;
        end else if (active) begin
            q_reg <= quotient;
            r_reg <= remainder;
            if (cnt == 5'd0)
                active <= 1'b0;
            else
                cnt <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO; stalls the pipeline
// while busy and owns the registered HI/LO write port.
//
// state | meaning
// IDLE  | accepts ops; MTHI/MTLO write directly from here
// MUL   | one-cycle multiply, product registered on exit
// DIV   | 32 divider iterations, sign-fixed result registered on exit
// WB    | write outputs asserted, completing op advances
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [1:0]  hilo_we,
    output logic        hilo_wediv,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    state_t      state, state_n;
    logic        accept;
    logic        div_start;
    logic        div_abort;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        acc_signed;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;
    logic        neg_q;
    logic        neg_r;
    logic        b_zero;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    logic [1:0]  we_n;
    logic        wediv_n;
    logic [31:0] hi_n;
    logic [31:0] lo_n;

    assign acc_signed = (op == OP_MULT) || (op == OP_DIV);
    assign abs_a      = (acc_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign abs_b      = (acc_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Sign-extending to 64 bits makes one unsigned multiply serve both forms
    assign ext_a   = {{32{op_signed & op_a[31]}}, op_a};
    assign ext_b   = {{32{op_signed & op_b[31]}}, op_b};
    assign product = ext_a * ext_b;

    assign q_fix = neg_q ? (32'd0 - div_q) : div_q;
    assign r_fix = neg_r ? (32'd0 - div_r) : div_r;

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (div_abort),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        stall     = 1'b0;
        we_n      = HILO_WE_NONE;
        wediv_n   = 1'b0;
        hi_n      = hi_wdata;
        lo_n      = lo_wdata;
        case (state)
            IDLE: begin
                if (op_valid && !flush) begin
                    if (is_mul_op(op)) begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_n = MUL;
                    end else if (is_div_op(op)) begin
                        accept    = 1'b1;
                        div_start = 1'b1;
                        stall     = 1'b1;
                        state_n   = DIV;
                    end else if (op == OP_MTHI) begin
                        we_n = HILO_WE_HI;
                        hi_n = src_a;
                    end else if (op == OP_MTLO) begin
                        we_n = HILO_WE_LO;
                        lo_n = src_a;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    stall   = 1'b1;
                    we_n    = HILO_WE_BOTH;
                    hi_n    = product[63:32];
                    lo_n    = product[31:0];
                    state_n = WB;
                end
            end
            DIV: begin
                if (flush) begin
                    div_abort = 1'b1;
                    state_n   = IDLE;
                end else begin
                    stall = 1'b1;
                    if (div_done) begin
                        wediv_n = 1'b1;
                        hi_n    = b_zero ? op_a : r_fix;
                        lo_n    = b_zero ? 32'hFFFF_FFFF : q_fix;
                        state_n = WB;
                    end
                end
            end
            WB: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            op_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            b_zero    <= 1'b0;
        end else if (accept) begin
            op_a      <= src_a;
            op_b      <= src_b;
            op_signed <= acc_signed;
            neg_q     <= acc_signed & (src_a[31] ^ src_b[31]);
            neg_r     <= acc_signed & src_a[31];
            b_zero    <= (src_b == 32'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hilo_we    <= HILO_WE_NONE;
            hilo_wediv <= 1'b0;
            hi_wdata   <= 32'd0;
            lo_wdata   <= 32'd0;
        end else begin
            hilo_we    <= we_n;
            hilo_wediv <= wediv_n;
            hi_wdata   <= hi_n;
            lo_wdata   <= lo_n;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl: latency, stall profile, HI/LO data,
// flush and asynchronous reset behaviour.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [1:0]  hilo_we;
    logic        hilo_wediv;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    muldiv_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .hilo_we    (hilo_we),
        .hilo_wediv (hilo_wediv),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with any visible activity over n cycles
    task automatic watch_quiet(input int n, output int events);
        events = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stall || busy || hilo_we != 2'b10 || hilo_wediv) events++;
            next_cycle();
        end
    endtask

    // Presents one op, holds it while stalled (pipeline behaviour) and
    // checks write cycle, stall count and result data.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input int exp_stalls,
                          input logic [1:0] exp_we, input logic exp_wediv,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic ck_hi, input logic ck_lo);
        int   cyc;
        int   stalls;
        logic last_stall;
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        cyc      = 0;
        stalls   = 0;
        while (cyc < 60) begin
            @(negedge clk);
            if (stall) stalls++;
            if (hilo_we != 2'b10 || hilo_wediv) break;
            last_stall = stall;
            next_cycle();
            if (!last_stall) op_valid = 1'b0;
            cyc++;
        end
        check_val({tag, " wcycle"}, 64'(cyc), 64'(exp_cyc));
        check_val({tag, " stalls"}, 64'(stalls), 64'(exp_stalls));
        check_val({tag, " we"}, 64'(hilo_we), 64'(exp_we));
        check_val({tag, " wediv"}, 64'(hilo_wediv), 64'(exp_wediv));
        if (ck_hi) check_val({tag, " hi"}, 64'(hi_wdata), 64'(exp_hi));
        if (ck_lo) check_val({tag, " lo"}, 64'(lo_wdata), 64'(exp_lo));
        next_cycle();
        op_valid = 1'b0;
        op       = 3'b000;
        @(negedge clk);
        check_val({tag, " post-we"}, 64'(hilo_we), 64'(2'b10));
        check_val({tag, " post-wediv"}, 64'(hilo_wediv), 64'(1'b0));
        check_val({tag, " post-busy"}, 64'(busy), 64'(1'b0));
        next_cycle();
    endtask

    initial begin
        int ev;
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 3'b000;
        src_a    = 32'd0;
        src_b    = 32'd0;
        flush    = 1'b0;

        repeat (2) @(negedge clk);
        check_val("reset we", 64'(hilo_we), 64'(2'b10));
        check_val("reset wediv", 64'(hilo_wediv), 64'(1'b0));
        check_val("reset hi", 64'(hi_wdata), 64'(0));
        check_val("reset lo", 64'(lo_wdata), 64'(0));
        check_val("reset stall", 64'(stall), 64'(0));
        check_val("reset busy", 64'(busy), 64'(0));
        next_cycle();
        rst = 1'b0;
        next_cycle();

        //        tag       op      a             b             cyc st  we     wdv hi            lo            ckh ckl
        run_op("mthi",  3'b101, 32'h12345678, 32'h0,        1,  0,  2'b01, 0, 32'h12345678, 32'h0,        1, 0);
        run_op("mtlo",  3'b110, 32'hCAFEF00D, 32'h0,        1,  0,  2'b00, 0, 32'h0,        32'hCAFEF00D, 0, 1);
        run_op("mult",  3'b001, 32'hFFFFFFFF, 32'h00000002, 2,  2,  2'b11, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 1);
        run_op("multu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 2,  2,  2'b11, 0, 32'h00000001, 32'hFFFFFFFE, 1, 1);
        run_op("mult2", 3'b001, 32'h80000000, 32'h80000000, 2,  2,  2'b11, 0, 32'h40000000, 32'h00000000, 1, 1);
        run_op("divu",  3'b100, 32'd100,      32'd7,        33, 33, 2'b10, 1, 32'd2,        32'd14,       1, 1);
        run_op("div",   3'b011, 32'hFFFFFFF9, 32'd2,        33, 33, 2'b10, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1);
        run_op("divpn", 3'b011, 32'd7,        32'hFFFFFFFE, 33, 33, 2'b10, 1, 32'd1,        32'hFFFFFFFD, 1, 1);
        run_op("divov", 3'b011, 32'h80000000, 32'hFFFFFFFF, 33, 33, 2'b10, 1, 32'h0,        32'h80000000, 1, 1);
        run_op("divu0", 3'b100, 32'd5,        32'd0,        33, 33, 2'b10, 1, 32'd5,        32'hFFFFFFFF, 1, 1);
        run_op("div0",  3'b011, 32'hFFFFFFF9, 32'd0,        33, 33, 2'b10, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 1);

        // Undefined op code and op_valid=0 must do nothing
        op_valid = 1'b1; op = 3'b111; src_a = 32'h55; src_b = 32'h3;
        watch_quiet(3, ev);
        check_val("op111 quiet", 64'(ev), 64'(0));
        op_valid = 1'b0; op = 3'b011;
        watch_quiet(3, ev);
        check_val("novalid quiet", 64'(ev), 64'(0));

        // Flush in IDLE on a MULT: no stall, no write
        op_valid = 1'b1; op = 3'b001; flush = 1'b1;
        @(negedge clk);
        check_val("flush idle stall", 64'(stall), 64'(0));
        next_cycle();
        op_valid = 1'b0; flush = 1'b0;
        watch_quiet(3, ev);
        check_val("flush idle quiet", 64'(ev), 64'(0));

        // Flush at DIV cycle 10
        op_valid = 1'b1; op = 3'b100; src_a = 32'd1000; src_b = 32'd3;
        repeat (10) next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check_val("flush div stall", 64'(stall), 64'(0));
        check_val("flush div busy", 64'(busy), 64'(1));
        next_cycle();
        flush = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        check_val("flush div busy next", 64'(busy), 64'(0));
        watch_quiet(40, ev);
        check_val("flush div no write", 64'(ev), 64'(0));
        run_op("mult post-flush", 3'b001, 32'd3, 32'd5, 2, 2, 2'b11, 0, 32'd0, 32'd15, 1, 1);

        // Asynchronous reset at DIV cycle 10
        op_valid = 1'b1; op = 3'b011; src_a = 32'd77; src_b = 32'd5;
        repeat (10) next_cycle();
        #2;
        rst = 1'b1; op_valid = 1'b0;
        #1;
        check_val("arst stall", 64'(stall), 64'(0));
        check_val("arst busy", 64'(busy), 64'(0));
        check_val("arst we", 64'(hilo_we), 64'(2'b10));
        check_val("arst wediv", 64'(hilo_wediv), 64'(0));
        check_val("arst hi", 64'(hi_wdata), 64'(0));
        check_val("arst lo", 64'(lo_wdata), 64'(0));
        next_cycle();
        rst = 1'b0;
        watch_quiet(40, ev);
        check_val("arst no write", 64'(ev), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for HI/LO-producing instructions (MULT, MULTU, DIV, DIVU, MTHI, MTLO) in the EX stage. It accepts one op from the pipeline and runs a 1-cycle registered multiply or a 32-iteration radix-2 divide. It stalls the pipeline while busy and drives the HI/LO register write port (we/wediv/hi/lo). Results reach the HI/LO register through this block only.

## Interface
Parameters: none.
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  EX-stage op present
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
- src_a  in  32  rs value (dividend / multiplicand / MTHI/MTLO data)
- src_b  in  32  rt value (divisor / multiplier)
- flush  in  1  cancel in-flight op
- stall  out  1  hold EX and earlier stages
- busy  out  1  state != IDLE
- hilo_we  out  2  11 write both, 01 HI only, 00 LO only, 10 no write
- hilo_wediv  out  1  divide result write (both HI and LO)
- hi_wdata  out  32  HI write data
- lo_wdata  out  32  LO write data

## Operation
- Reset values: state IDLE, hilo_we=2'b10, hilo_wediv=0, hi_wdata=lo_wdata=0, stall=0, busy=0.
- All write outputs are registered. When no write is issued they return to hilo_we=10 and wediv=0, and the data holds its last value.
- States:
  - IDLE: accepts op_valid.
  - MUL: one compute cycle.
  - DIV: 32 iterations, counter 5 bits, 31 down to 0.
  - WB: write outputs asserted.
- IDLE + MTHI: next cycle hilo_we=01, hi_wdata=src_a. No stall, no state change.
- IDLE + MTLO: same as MTHI, with hilo_we=00 and lo_wdata=src_a.
- IDLE + MULT/MULTU: capture operands and go to MUL. In MUL, compute the 64-bit product (signed for MULT, unsigned for MULTU), register {hi,lo} with hilo_we=11, then go to WB.
- IDLE + DIV/DIVU:
  - Capture |a| and |b|; for DIV also record the signs. Go to DIV.
  - Each DIV cycle does one restoring shift-subtract step.
  - At the end of the last iteration, apply the sign fix and register lo=quotient, hi=remainder, wediv=1, hilo_we=10. Go to WB.
- Signed DIV rules: quotient is negated when sign(a)^sign(b). Remainder takes the sign of a.
- 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero (either form): quotient 0xFFFFFFFF, remainder = src_a unchanged. This still costs the full latency.
- WB: stall=0, and op_valid/op are ignored because they show the completing op, which advances at this edge. Go to IDLE.
- stall = (state==IDLE & op_valid & op∈{MULT,MULTU,DIV,DIVU} & ~flush) | state∈{MUL,DIV}.
- flush in IDLE, MUL or DIV: go to IDLE next cycle, no write issued, stall=0 in the flush cycle.
- flush in WB does not cancel the write; the op is older than the flushed instructions.
- Op 000, op codes 111, and op_valid=0: no action.

## Timing
- Acceptance is cycle 0.
- MTHI/MTLO: write asserted in cycle 1. HI/LO are updated at the end of cycle 1.
- MULT/MULTU: stall=1 in cycles 0–1. WB, with hilo_we=11, is cycle 2.
- DIV/DIVU: stall=1 in cycles 0–32 (DIV occupies cycles 1–32). WB, with wediv=1, is cycle 33.
- The next op can be accepted in the cycle after WB.
- Asynchronous rst mid-operation: immediate return to reset values. No write is issued.

## Structure
- Package muldiv_pkg holds:
  - op code localparams;
  - the state enum (IDLE, MUL, DIV, WB);
  - HILO_WE_BOTH=2'b11, HILO_WE_HI=2'b01, HILO_WE_LO=2'b00, HILO_WE_NONE=2'b10.
- Sub-module div_radix2 holds the unsigned 32-iteration core with start/done/abort, quotient/remainder registers and the counter.
- muldiv_ctrl holds the FSM, the sign handling, the multiplier and the output registers.

## Test plan
- Reset asserted mid-DIV (cycle 10) → all outputs at reset values immediately, no wediv pulse afterwards.
- MTHI src_a=0x12345678 → cycle 1: hilo_we=01, hi_wdata=0x12345678, stall never 1.
- MULT 0xFFFFFFFF×0x00000002 → stall cycles 0–1; cycle 2: hilo_we=11, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands gives hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 100/7 → cycle 33: wediv=1, lo=14, hi=2. DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- flush at DIV cycle 10 → stall=0 in that cycle, no write ever, busy=0 next cycle. A MULT presented afterwards completes normally with WB at cycle 2.
